// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl
// Sequencing controller for the round-key generator. Accepts cipher keys,
// launches one expansion per new key (skipping keys that match the cached
// schedule), holds off block starts while round keys are being rewritten and
// verifies that every expansion wrote the expected number of round keys.
module key_sched_ctrl #(
  parameter int KEY_BITS    = 256,
  parameter int RK_CNT_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [KEY_BITS-1:0]    key,
  input  logic [1:0]             key_mode,
  input  logic                   flush,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  input  logic                   blk_done,
  output logic                   gen_en,
  output logic [KEY_BITS-1:0]    gen_key,
  output logic                   gen_aes128_mode,
  output logic                   gen_aes256_mode,
  output logic [RK_CNT_BITS-1:0] gen_rounds_total,
  input  logic                   gen_w_e,
  input  logic                   gen_done,
  output logic                   keys_valid,
  output logic                   key_err,
  output logic                   sched_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_EXPAND = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_256 = 2'b10;

  logic [2:0]             state;
  logic [1:0]             cache_mode;
  logic                   cache_valid;
  logic                   core_busy;
  logic                   flush_pend;
  logic                   drain_to_idle;
  logic [RK_CNT_BITS:0]   wr_cnt;

  logic                   mode_legal;
  logic                   hit;
  logic                   key_acc;
  logic                   blk_acc;
  logic                   drain_done;
  logic [RK_CNT_BITS-1:0] mode_rounds;
  logic [RK_CNT_BITS:0]   wr_final;
  logic [RK_CNT_BITS:0]   wr_target;

  // A pending flush disqualifies the cache so a flushed schedule is never reused.
  assign mode_legal  = (key_mode == MODE_128) || (key_mode == MODE_256);
  assign hit         = cache_valid && !flush_pend && (key == gen_key) && (key_mode == cache_mode);
  assign key_ready   = (state == S_IDLE) || (state == S_READY);
  assign key_acc     = key_valid && key_ready;
  assign blk_ready   = (state == S_READY) && !core_busy && !(key_valid && !hit) && !flush_pend;
  assign blk_acc     = blk_valid && blk_ready;
  assign gen_en      = (state == S_START);
  assign drain_done  = !core_busy || blk_done;
  assign mode_rounds = (key_mode == MODE_128) ? RK_CNT_BITS'(10) :
                       (key_mode == MODE_256) ? RK_CNT_BITS'(14) : '0;
  assign wr_final    = wr_cnt + {{RK_CNT_BITS{1'b0}}, gen_w_e};
  assign wr_target   = {1'b0, gen_rounds_total} + {{RK_CNT_BITS{1'b0}}, 1'b1};

  // Track the single outstanding block in the cipher core.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_busy <= 1'b0;
    end else if (blk_acc) begin
      core_busy <= 1'b1;
    end else if (blk_done) begin
      core_busy <= 1'b0;
    end
  end

  // Capture the accepted key and its mode; these stay stable for the generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_key          <= '0;
      cache_mode       <= 2'b00;
      gen_aes128_mode  <= 1'b0;
      gen_aes256_mode  <= 1'b0;
      gen_rounds_total <= '0;
    end else if (key_acc) begin
      gen_key          <= key;
      cache_mode       <= key_mode;
      gen_aes128_mode  <= (key_mode == MODE_128);
      gen_aes256_mode  <= (key_mode == MODE_256);
      gen_rounds_total <= mode_rounds;
    end
  end

  // Main sequencer: key acceptance, drain, expansion, write-count check and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cache_valid   <= 1'b0;
      keys_valid    <= 1'b0;
      key_err       <= 1'b0;
      sched_err     <= 1'b0;
      flush_pend    <= 1'b0;
      drain_to_idle <= 1'b0;
      wr_cnt        <= '0;
    end else begin
      key_err <= 1'b0;
      if (flush) begin
        flush_pend <= 1'b1;
      end
      case (state)
        S_IDLE, S_READY: begin
          if (state == S_IDLE) begin
            flush_pend <= 1'b0;
          end
          if (key_acc) begin
            if (!mode_legal) begin
              key_err       <= 1'b1;
              cache_valid   <= 1'b0;
              keys_valid    <= 1'b0;
              flush_pend    <= 1'b0;
              drain_to_idle <= 1'b1;
              state         <= core_busy ? S_DRAIN : S_IDLE;
            end else if (!hit) begin
              cache_valid   <= 1'b0;
              keys_valid    <= 1'b0;
              flush_pend    <= 1'b0;
              drain_to_idle <= 1'b0;
              state         <= core_busy ? S_DRAIN : S_START;
            end
          end else if ((state == S_READY) && flush_pend && !core_busy) begin
            cache_valid <= 1'b0;
            keys_valid  <= 1'b0;
            flush_pend  <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state         <= drain_to_idle ? S_IDLE : S_START;
            drain_to_idle <= 1'b0;
          end
        end
        S_START: begin
          wr_cnt <= '0;
          state  <= S_EXPAND;
        end
        S_EXPAND: begin
          wr_cnt <= wr_final;
          if (gen_done) begin
            if (wr_final == wr_target) begin
              cache_valid <= 1'b1;
              keys_valid  <= 1'b1;
              state       <= S_READY;
            end else begin
              sched_err   <= 1'b1;
              cache_valid <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl
// Self-checking bench for key_sched_ctrl with a behavioural round-key
// generator and a scoreboard of the key/mode expected at each gen_en.
module tb_key_sched_ctrl;

  localparam int KB = 256;
  localparam int RB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key_valid = 1'b0;
  logic          key_ready;
  logic [KB-1:0] key = '0;
  logic [1:0]    key_mode = 2'b00;
  logic          flush = 1'b0;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic          blk_done = 1'b0;
  logic          gen_en;
  logic [KB-1:0] gen_key;
  logic          gen_aes128_mode;
  logic          gen_aes256_mode;
  logic [RB-1:0] gen_rounds_total;
  logic          gen_w_e = 1'b0;
  logic          gen_done = 1'b0;
  logic          keys_valid;
  logic          key_err;
  logic          sched_err;

  localparam logic [KB-1:0] K1 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [KB-1:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [KB-1:0] K3 = 256'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    logic [KB-1:0] k;
    logic          a128;
    logic          a256;
    logic [RB-1:0] rounds;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int gen_rem = 0;
  int gen_pulse = 0;
  bit drop_one = 1'b0;

  key_sched_ctrl #(.KEY_BITS(KB), .RK_CNT_BITS(RB)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_ready(key_ready), .key(key), .key_mode(key_mode),
    .flush(flush), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_done(blk_done),
    .gen_en(gen_en), .gen_key(gen_key), .gen_aes128_mode(gen_aes128_mode),
    .gen_aes256_mode(gen_aes256_mode), .gen_rounds_total(gen_rounds_total),
    .gen_w_e(gen_w_e), .gen_done(gen_done),
    .keys_valid(keys_valid), .key_err(key_err), .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: R+1 write strobes starting the cycle after gen_en, done on the last.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        gen_rem = 0; gen_w_e = 1'b0; gen_done = 1'b0;
      end else begin
        if (gen_rem > 0) begin
          gen_pulse++;
          gen_w_e  = !(drop_one && gen_pulse == 3);
          gen_done = (gen_rem == 1);
          gen_rem--;
        end else begin
          gen_w_e = 1'b0; gen_done = 1'b0;
        end
        if (gen_en) begin
          gen_rem   = int'(gen_rounds_total) + 1;
          gen_pulse = 0;
        end
      end
    end
  end

  // Scoreboard consumer: every gen_en must match the oldest expected expansion.
  always @(negedge clk) begin
    if (gen_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_gen_en: gen_en=1 required 0 (no expansion expected)");
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (gen_key !== mon_e.k) begin
          errors++;
          $display("[TB] FAIL sb_gen_key: got %h required %h", gen_key, mon_e.k);
        end
        checks++;
        if ({gen_aes128_mode, gen_aes256_mode, gen_rounds_total} !== {mon_e.a128, mon_e.a256, mon_e.rounds}) begin
          errors++;
          $display("[TB] FAIL sb_mode: got a128=%0b a256=%0b rounds=%0d required a128=%0b a256=%0b rounds=%0d",
                   gen_aes128_mode, gen_aes256_mode, gen_rounds_total, mon_e.a128, mon_e.a256, mon_e.rounds);
        end
      end
    end
  end

  // Offer one key (bounded wait for key_ready); optionally expect an expansion.
  task automatic applyStimulus(input logic [KB-1:0] k, input logic [1:0] m, input bit expect_gen);
    int waited = 0;
    exp_t e;
    @(negedge clk);
    key = k; key_mode = m; key_valid = 1'b1;
    while (!key_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!key_ready) begin
      errors++;
      $display("[TB] FAIL key_accept: key_ready=%0b required 1", key_ready);
      key_valid = 1'b0;
    end else begin
      if (expect_gen) begin
        e.k = k;
        e.a128 = (m == 2'b00);
        e.a256 = (m == 2'b10);
        e.rounds = (m == 2'b00) ? 4'd10 : 4'd14;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      key_valid = 1'b0;
    end
  endtask

  // Hold reset for one edge (entered at a negedge) and check every output.
  task automatic test_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s_key_ready: got %0b required 1", tag, key_ready); end
    checks++;
    if ({blk_ready, gen_en, keys_valid, key_err, sched_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL %s_flags: got blk_ready,gen_en,keys_valid,key_err,sched_err=%b required 00000", tag,
               {blk_ready, gen_en, keys_valid, key_err, sched_err});
    end
    checks++;
    if (gen_key !== '0) begin errors++; $display("[TB] FAIL %s_gen_key: got %h required 0", tag, gen_key); end
    checks++;
    if ({gen_aes128_mode, gen_aes256_mode, gen_rounds_total} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL %s_mode: got %b required 000000", tag, {gen_aes128_mode, gen_aes256_mode, gen_rounds_total});
    end
    reset = 1'b0;
  endtask

  // AES-128 miss with idle core: gen_en at T+1, 11 writes, keys_valid at T+13.
  task automatic test_aes128;
    int en_cnt = 0, en_first = -1, we_cnt = 0, kv_first = -1, k;
    applyStimulus(K1, 2'b00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k = cyc - acc_cyc;
      if (gen_en) begin en_cnt++; if (en_first < 0) en_first = k; end
      if (gen_w_e) we_cnt++;
      if (keys_valid && kv_first < 0) kv_first = k;
    end
    checks++;
    if (en_cnt != 1 || en_first != 0) begin errors++; $display("[TB] FAIL a128_gen_en: got count=%0d first=%0d required 1 at 0", en_cnt, en_first); end
    checks++;
    if (we_cnt != 11) begin errors++; $display("[TB] FAIL a128_writes: got %0d required 11", we_cnt); end
    checks++;
    if (kv_first != 12) begin errors++; $display("[TB] FAIL a128_keys_valid_time: got %0d required 12", kv_first); end
    checks++;
    if (sched_err !== 1'b0) begin errors++; $display("[TB] FAIL a128_sched_err: got %0b required 0", sched_err); end
  endtask

  // AES-256 expansion, then the same key again together with a block request.
  task automatic test_aes256_hit;
    int kv_first = -1, kv_drop = 0, en_cnt = 0, k;
    applyStimulus(K2, 2'b10, 1'b1);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      k = cyc - acc_cyc;
      if (keys_valid && kv_first < 0) kv_first = k;
    end
    checks++;
    if (kv_first != 16) begin errors++; $display("[TB] FAIL a256_keys_valid_time: got %0d required 16", kv_first); end
    @(negedge clk);
    key = K2; key_mode = 2'b10; key_valid = 1'b1; blk_valid = 1'b1;
    checks++;
    if (blk_ready !== 1'b1 || key_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hit_same_cycle: got blk_ready=%0b key_ready=%0b required 1 1", blk_ready, key_ready);
    end
    if (!keys_valid) kv_drop++;
    @(posedge clk);
    #1;
    key_valid = 1'b0; blk_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!keys_valid) kv_drop++;
      if (gen_en) en_cnt++;
    end
    checks++;
    if (kv_drop != 0 || en_cnt != 0) begin errors++; $display("[TB] FAIL hit_no_bubble: got kv_low=%0d gen_en=%0d required 0 0", kv_drop, en_cnt); end
    checks++;
    if (blk_ready !== 1'b0) begin errors++; $display("[TB] FAIL hit_core_busy: got blk_ready=%0b required 0", blk_ready); end
    blk_done = 1'b1;
    @(negedge clk);
    blk_done = 1'b0;
    checks++;
    if (blk_ready !== 1'b1) begin errors++; $display("[TB] FAIL hit_core_free: got blk_ready=%0b required 1", blk_ready); end
  endtask

  // New AES-128 key while a block is in flight: drain, then expand after blk_done.
  task automatic test_drain;
    int bad = 0, en_first = -1, kv_first = -1, dcy, k;
    @(negedge clk);
    blk_valid = 1'b1;
    checks++;
    if (blk_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_blk_grant: got %0b required 1", blk_ready); end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    applyStimulus(K1, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (gen_en || blk_ready || keys_valid || key_ready) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL drain_hold: got %0d bad cycles required 0", bad); end
    @(negedge clk);
    blk_done = 1'b1;
    dcy = cyc;
    @(negedge clk);
    blk_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      k = cyc - dcy;
      if (gen_en && en_first < 0) en_first = k;
      if (keys_valid && kv_first < 0) kv_first = k;
      @(negedge clk);
    end
    checks++;
    if (en_first != 1) begin errors++; $display("[TB] FAIL drain_gen_en: got offset %0d required 1", en_first); end
    checks++;
    if (kv_first != 13) begin errors++; $display("[TB] FAIL drain_keys_valid: got offset %0d required 13", kv_first); end
  endtask

  // Illegal mode 2'b01: one key_err pulse, schedule invalidated, no expansion.
  task automatic test_illegal;
    int err_cnt = 0, err_first = -1, en_cnt = 0, kv_cnt = 0, k;
    applyStimulus(K3, 2'b01, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      k = cyc - acc_cyc;
      if (key_err) begin err_cnt++; if (err_first < 0) err_first = k; end
      if (gen_en) en_cnt++;
      if (keys_valid) kv_cnt++;
    end
    checks++;
    if (err_cnt != 1 || err_first != 0) begin errors++; $display("[TB] FAIL illegal_key_err: got count=%0d first=%0d required 1 at 0", err_cnt, err_first); end
    checks++;
    if (en_cnt != 0 || kv_cnt != 0) begin errors++; $display("[TB] FAIL illegal_quiet: got gen_en=%0d kv=%0d required 0 0", en_cnt, kv_cnt); end
    checks++;
    if (key_ready !== 1'b1 || blk_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_idle: got key_ready=%0b blk_ready=%0b required 1 0", key_ready, blk_ready);
    end
  endtask

  // Dropped write strobe: sched_err sets the cycle after gen_done and stays set.
  task automatic test_drop;
    int waited = 0;
    drop_one = 1'b1;
    applyStimulus(K1, 2'b00, 1'b1);
    @(negedge clk);
    while (!gen_done && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!gen_done) begin
      errors++;
      $display("[TB] FAIL drop_gen_done_timeout: gen_done=%0b required 1", gen_done);
    end
    @(negedge clk);
    drop_one = 1'b0;
    checks++;
    if (sched_err !== 1'b1 || keys_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_sched_err: got sched_err=%0b keys_valid=%0b required 1 0", sched_err, keys_valid);
    end
    applyStimulus(K1, 2'b00, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (keys_valid !== 1'b1 || sched_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_sticky: got keys_valid=%0b sched_err=%0b required 1 1", keys_valid, sched_err);
    end
  endtask

  // Flush during expansion, then reset in the middle of a later expansion.
  task automatic test_flush_reset;
    int kv_high = 0, kv_after = 0, en_after = 0, k;
    applyStimulus(K2, 2'b10, 1'b1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      k = cyc - acc_cyc;
      flush = (k == 5);
      if (keys_valid) kv_high++;
    end
    checks++;
    if (kv_high != 1) begin errors++; $display("[TB] FAIL flush_kv_pulse: got %0d cycles required 1", kv_high); end
    checks++;
    if (key_ready !== 1'b1 || blk_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle: got key_ready=%0b blk_ready=%0b required 1 0", key_ready, blk_ready);
    end
    applyStimulus(K2, 2'b10, 1'b1);
    @(negedge clk);
    checks++;
    if (gen_en !== 1'b1) begin errors++; $display("[TB] FAIL flush_reexpand: got gen_en=%0b required 1", gen_en); end
    repeat (4) @(negedge clk);
    test_reset("reset_mid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (keys_valid) kv_after++;
      if (gen_en) en_after++;
    end
    checks++;
    if (kv_after != 0 || en_after != 0) begin
      errors++;
      $display("[TB] FAIL reset_discard: got kv=%0d gen_en=%0d required 0 0", kv_after, en_after);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset("reset");
    test_aes128;
    test_aes256_hit;
    test_drain;
    test_illegal;
    test_drop;
    test_flush_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL sb_leftover: got %0d entries required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
